// File: rtl/kamikaze_mem_arb.sv
// kamikaze_mem_arb
//   Round-robin arbiter sharing one single-port synchronous 32-bit word memory
//   between the instruction-fetch port (I) and the data load/store port (D).
//   At most one access is issued per cycle. The granted port sees a registered
//   acknowledge one cycle later, together with read data muxed straight from
//   the memory. Word indices at or beyond MEM_WORDS are answered with an error
//   acknowledge and never reach the array.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   i_req_i, i_addr_i       instruction read request and byte address
//   i_ack_o, i_rdata_o,     completion pulse, fetched word, out-of-range flag
//   i_err_o
//   d_req_i, d_addr_i,      data request, byte address, byte write strobes
//   d_we_i, d_wdata_i       (0 = read), write data
//   d_ack_o, d_rdata_o,     completion pulse, read word, out-of-range flag
//   d_err_o
//   mem_en_o, mem_we_o,     memory enable, byte write enables, word address,
//   mem_addr_o, mem_wdata_o write data
//   mem_rdata_i             memory read data, one cycle after a read enable
module kamikaze_mem_arb #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [31:0]   i_addr_i,
  output logic          i_ack_o,
  output logic [31:0]   i_rdata_o,
  output logic          i_err_o,
  input  logic          d_req_i,
  input  logic [31:0]   d_addr_i,
  input  logic [3:0]    d_we_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_ack_o,
  output logic [31:0]   d_rdata_o,
  output logic          d_err_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

  port_e       last_q, last_d;
  logic        i_ack_q, i_ack_d;
  logic        i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic        d_rd_q,  d_rd_d;

  logic [29:0] i_idx, d_idx;
  logic        i_ok, d_ok;
  logic        i_elig, d_elig;
  logic        gnt_i, gnt_d;

  // Byte-lane bits are ignored by design.
  logic        unused_ok;
  assign unused_ok = ^{i_addr_i[1:0], d_addr_i[1:0]};

  assign i_idx = i_addr_i[31:2];
  assign d_idx = d_addr_i[31:2];
  assign i_ok  = (i_idx < LIMIT);
  assign d_ok  = (d_idx < LIMIT);

  // A port in its ack cycle is masked so its still-held request is not
  // granted twice. Grants are also held off while reset is asserted so a
  // request held across reset cannot touch the memory.
  assign i_elig = rst_i & i_req_i & ~i_ack_q;
  assign d_elig = rst_i & d_req_i & ~d_ack_q;

  // On contention the port that was not granted last wins.
  assign gnt_i = i_elig & (~d_elig | (last_q == PORT_D));
  assign gnt_d = d_elig & ~gnt_i;

  always_comb begin
    last_d      = last_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rd_d      = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_i) begin
      last_d  = PORT_I;
      i_ack_d = 1'b1;
      i_err_d = ~i_ok;
      if (i_ok) begin
        mem_en_o   = 1'b1;
        mem_addr_o = i_idx[AW-1:0];
      end
    end else if (gnt_d) begin
      last_d  = PORT_D;
      d_ack_d = 1'b1;
      d_err_d = ~d_ok;
      d_rd_d  = (d_we_i == '0);
      if (d_ok) begin
        mem_en_o    = 1'b1;
        mem_we_o    = d_we_i;
        mem_addr_o  = d_idx[AW-1:0];
        mem_wdata_o = d_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q  <= PORT_D;
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      d_rd_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      i_ack_q <= i_ack_d;
      i_err_q <= i_err_d;
      d_ack_q <= d_ack_d;
      d_err_q <= d_err_d;
      d_rd_q  <= d_rd_d;
    end
  end

  assign i_ack_o   = i_ack_q;
  assign i_err_o   = i_err_q;
  assign d_ack_o   = d_ack_q;
  assign d_err_o   = d_err_q;
  assign i_rdata_o = (i_ack_q && !i_err_q) ? mem_rdata_i : '0;
  assign d_rdata_o = (d_ack_q && !d_err_q && d_rd_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_kamikaze_mem_arb.sv
// Bench for kamikaze_mem_arb: behavioural word memory on the memory port,
// a per-port queue of expected acknowledges, a vector table of single
// accesses and hand-written sequences for arbitration and reset corners.
module tb_kamikaze_mem_arb;
  localparam int unsigned MW  = 4096;
  localparam int unsigned AWL = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_req;
  logic [31:0]    i_addr;
  logic           i_ack_o, i_err_o;
  logic [31:0]    i_rdata_o;
  logic           d_req;
  logic [31:0]    d_addr;
  logic [3:0]     d_we;
  logic [31:0]    d_wdata;
  logic           d_ack_o, d_err_o;
  logic [31:0]    d_rdata_o;
  logic           mem_en_o;
  logic [3:0]     mem_we_o;
  logic [AWL-1:0] mem_addr_o;
  logic [31:0]    mem_wdata_o;
  logic [31:0]    mem_rdata = '1;

  kamikaze_mem_arb #(.MEM_WORDS(MW), .AW(AWL)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack_o),
    .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous memory.
  logic [31:0] mem [0:MW-1];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o == 4'h0) mem_rdata <= mem[mem_addr_o];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];
  int i_acks = 0;
  int d_acks = 0;

  // Scoreboard: every ack pops one expected result; idle rdata must be 0.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (i_ack_o) begin
        i_acks++;
        if (i_q.size() == 0) chk("i_ack_unexpected", 32'(i_ack_o), 32'd0);
        else begin
          e = i_q.pop_front();
          chk("i_err", 32'(i_err_o), 32'(e.err));
          chk("i_rdata", i_rdata_o, e.rdata);
        end
      end else chk("i_rdata_idle", i_rdata_o, 32'h0);
      if (d_ack_o) begin
        d_acks++;
        if (d_q.size() == 0) chk("d_ack_unexpected", 32'(d_ack_o), 32'd0);
        else begin
          e = d_q.pop_front();
          chk("d_err", 32'(d_err_o), 32'(e.err));
          chk("d_rdata", d_rdata_o, e.rdata);
        end
      end else chk("d_rdata_idle", d_rdata_o, 32'h0);
    end
  end

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  // Called at #1 after a rising edge with no other request pending.
  task automatic access(input vec_t v, output int ack_cyc);
    exp_t e;
    int   g;
    logic got;
    e.err = v.err;
    e.rdata = v.rdata;
    if (v.is_d) begin
      d_q.push_back(e);
      d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
    end else begin
      i_q.push_back(e);
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    g = cyc;
    chk("grant_mem_en", 32'(mem_en_o), 32'(!v.err));
    chk("grant_mem_we", 32'(mem_we_o), (v.is_d && !v.err) ? 32'(v.we) : 32'h0);
    if (!v.err) chk("grant_mem_addr", 32'(mem_addr_o), 32'(v.addr[13:2]));
    if (v.is_d && !v.err && v.we != 4'h0) chk("grant_mem_wdata", mem_wdata_o, v.wdata);
    got = 1'b0;
    ack_cyc = -1;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (v.is_d ? d_ack_o : i_ack_o) begin
        got = 1'b1;
        ack_cyc = cyc;
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      i_q.delete();
      d_q.delete();
    end else chk("ack_latency", 32'(ack_cyc - g), 32'd1);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  vec_t vt[11];
  int   acyc[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int dummy;
    vec_t v;
    vt[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[1]  = '{1'b1, 32'h0000_0020, 4'h3, 32'h1234_5678, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 32'h0000_0020, 4'h0, 32'h0,         1'b0, 32'hAAAA_5678};
    vt[3]  = '{1'b1, 32'h0000_4000, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_3FFC, 4'h0, 32'h0,         1'b0, 32'h1357_9BDF};
    vt[5]  = '{1'b0, 32'h0000_3FFC, 4'h0, 32'h0,         1'b0, 32'h1357_9BDF};
    vt[6]  = '{1'b0, 32'h8000_0000, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[7]  = '{1'b1, 32'h0000_4000, 4'hF, 32'h5555_5555, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 32'h0BAD_F00D};
    vt[9]  = '{1'b1, 32'h0000_0020, 4'hC, 32'h9ABC_0000, 1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         1'b0, 32'h9ABC_5678};

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
    mem[0] = 32'h0BAD_F00D;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hAAAA_AAAA;
    mem[4095] = 32'h1357_9BDF;
    mem[64] = 32'h1111_2222;
    mem[128] = 32'h3333_4444;
    repeat (3) @(negedge clk);
    chk("rst_i_ack", 32'(i_ack_o), 32'd0);
    chk("rst_d_ack", 32'(d_ack_o), 32'd0);
    chk("rst_i_err", 32'(i_err_o), 32'd0);
    chk("rst_d_err", 32'(d_err_o), 32'd0);
    chk("rst_i_rdata", i_rdata_o, 32'h0);
    chk("rst_d_rdata", d_rdata_o, 32'h0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table of isolated single-port accesses.
    for (int k = 0; k < 11; k++) access(vt[k], acyc[k]);
    chk("d_wr_rd_ack_gap", 32'(acyc[2] - acyc[1]), 32'd2);

    // Contested grant after an I access: D first, then I.
    v = '{1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF};
    access(v, dummy);
    i_q.push_back('{1'b0, 32'hDEAD_BEEF});
    d_q.push_back('{1'b0, 32'h1357_9BDF});
    i_req = 1'b1; i_addr = 32'h0000_0010;
    d_req = 1'b1; d_addr = 32'h0000_3FFC; d_we = 4'h0;
    @(negedge clk);
    chk("contend_first_en", 32'(mem_en_o), 32'd1);
    chk("contend_first_addr", 32'(mem_addr_o), 32'd4095);
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    chk("contend_second_addr", 32'(mem_addr_o), 32'd4);
    chk("contend_d_ack", 32'(d_ack_o), 32'd1);
    @(posedge clk); #1; i_req = 1'b0;
    @(negedge clk);
    chk("contend_i_ack", 32'(i_ack_o), 32'd1);
    chk("contend_idle_en", 32'(mem_en_o), 32'd0);
    @(posedge clk); #1;

    // Both requesting continuously from reset: I, D, I, D ...
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i_q.delete(); d_q.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      i_q.push_back('{1'b0, 32'h1111_2222});
      d_q.push_back('{1'b0, 32'h3333_4444});
    end
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_addr = 32'h0000_0200; d_we = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_mem_en", 32'(mem_en_o), 32'd1);
      chk("rr_mem_addr", 32'(mem_addr_o), (k % 2 == 0) ? 32'd64 : 32'd128);
      chk("rr_i_ack", 32'(i_ack_o), 32'(k % 2 == 1));
      chk("rr_d_ack", 32'(d_ack_o), 32'(k % 2 == 0 && k > 0));
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_i_q_drained", 32'(i_q.size()), 32'd0);
    chk("rr_d_q_drained", 32'(d_q.size()), 32'd0);

    // Reset in the cycle after an I grant; held request re-granted once.
    @(posedge clk); #1;
    i_q.push_back('{1'b0, 32'hDEAD_BEEF});
    i_req = 1'b1; i_addr = 32'h0000_0010;
    @(negedge clk);
    chk("rstmid_grant_en", 32'(mem_en_o), 32'd1);
    @(posedge clk); #1;
    chk("rstmid_ack_before", 32'(i_ack_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack_dropped", 32'(i_ack_o), 32'd0);
    i_q.delete();
    @(negedge clk);
    chk("rstmid_held_no_en", 32'(mem_en_o), 32'd0);
    @(negedge clk);
    a0 = i_acks;
    i_q.push_back('{1'b0, 32'hDEAD_BEEF});
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (i_ack_o && i_req) begin
        @(posedge clk); #1;
        i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    chk("rstmid_single_ack", 32'(i_acks - a0), 32'd1);
    chk("rstmid_q_drained", 32'(i_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
